// File: rtl/sync_fifo_flopenrc.sv
// Single-clock valid/ready FIFO with synchronous flush and occupancy/almost-full status.
// Latency: one cycle from push to rd_valid (first-word fall-through, no empty-side bypass).
// Backpressure: wr_ready drops when full, during clear and during reset; no full-side pass-through.
module sync_fifo_flopenrc #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                       ph1,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_AF   = CW'(AFULL);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;
    logic             active;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshakes depend only on registered state, reset and clear.
    assign active      = reset & ~clear;
    assign wr_ready    = active & (count_q != COUNT_FULL);
    assign rd_valid    = active & (count_q != '0);
    assign rd_data     = rd_valid ? mem[rptr] : '0;
    assign count       = count_q;
    assign almost_full = reset & (count_q >= COUNT_AF);

    assign push = wr_valid & wr_ready;
    assign pop  = rd_valid & rd_ready;

    always_comb begin
        count_nxt = count_q;
        unique case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (clear) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            count_q <= count_nxt;
        end
    end

    // Storage is deliberately unreset; push is already gated off by reset and clear.
    always_ff @(posedge ph1) begin
        if (push) mem[wptr] <= wr_data;
    end

endmodule

// File: tb/tb_sync_fifo_flopenrc.sv
// Directed bench for sync_fifo_flopenrc: a DEPTH=4 instance for most steps, a DEPTH=3 instance for wrap.
module tb_sync_fifo_flopenrc;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        clear;

    logic        wv4, wr4, rv4, rr4, af4;
    logic [31:0] wd4, rd4;
    logic [2:0]  cnt4;

    logic        wv3, wr3, rv3, rr3, af3;
    logic [31:0] wd3, rd3;
    logic [1:0]  cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 ph1 = ~ph1;

    sync_fifo_flopenrc #(.WIDTH(32), .DEPTH(4)) dut4 (
        .ph1(ph1), .reset(reset), .clear(clear),
        .wr_valid(wv4), .wr_ready(wr4), .wr_data(wd4),
        .rd_valid(rv4), .rd_ready(rr4), .rd_data(rd4),
        .count(cnt4), .almost_full(af4)
    );

    sync_fifo_flopenrc #(.WIDTH(32), .DEPTH(3)) dut3 (
        .ph1(ph1), .reset(reset), .clear(clear),
        .wr_valid(wv3), .wr_ready(wr3), .wr_data(wd3),
        .rd_valid(rv3), .rd_ready(rr3), .rd_data(rd3),
        .count(cnt3), .almost_full(af3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    logic [31:0] words [10];
    logic [31:0] got;
    int sent, rcvd, mcnt, cyc;
    logic mpush, mpop;

    initial begin
        reset = 1'b0; clear = 1'b0;
        wv4 = 1'b1; wd4 = 32'hEE; rr4 = 1'b0;
        wv3 = 1'b0; wd3 = '0;     rr3 = 1'b0;

        // Reset held for two edges with a write pending
        step();
        chk("rst_wr_ready", {31'b0, wr4}, 32'd0);
        chk("rst_rd_valid", {31'b0, rv4}, 32'd0);
        chk("rst_rd_data",  rd4,          32'd0);
        chk("rst_afull",    {31'b0, af4}, 32'd0);
        step();
        chk("rst_wr_ready2", {31'b0, wr4}, 32'd0);
        reset = 1'b1; wv4 = 1'b0;
        #1;
        chk("rel_count",    {29'b0, cnt4}, 32'd0);
        chk("rel_wr_ready", {31'b0, wr4},  32'd1);
        chk("rel_rd_valid", {31'b0, rv4},  32'd0);
        chk("rel_count3",   {30'b0, cnt3}, 32'd0);

        // Fill to full with no reads, then drain in order
        for (int i = 0; i < 4; i++) begin
            wv4 = 1'b1; wd4 = 32'hA0 + 32'(i);
            step();
            chk("fill_count", {29'b0, cnt4}, 32'(i + 1));
            chk("fill_afull", {31'b0, af4},  (i + 1 >= 3) ? 32'd1 : 32'd0);
            chk("fill_wr_ready", {31'b0, wr4}, (i + 1 == 4) ? 32'd0 : 32'd1);
        end
        wv4 = 1'b0; rr4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_rd_valid", {31'b0, rv4}, 32'd1);
            chk("drain_rd_data",  rd4, 32'hA0 + 32'(i));
            step();
            chk("drain_count", {29'b0, cnt4}, 32'(3 - i));
        end
        chk("drain_rd_valid_end", {31'b0, rv4}, 32'd0);
        chk("drain_rd_data_end",  rd4, 32'd0);
        rr4 = 1'b0;

        // Empty FIFO: push 0x12, visible only after the edge
        wv4 = 1'b1; wd4 = 32'h12;
        chk("lat_rd_valid_pre", {31'b0, rv4}, 32'd0);
        step();
        chk("lat_rd_valid_post", {31'b0, rv4}, 32'd1);
        chk("lat_rd_data_post",  rd4, 32'h12);

        // Simultaneous push/pop at count=2 and at full
        wd4 = 32'h34;
        step();
        chk("pp_count2", {29'b0, cnt4}, 32'd2);
        wd4 = 32'h55; rr4 = 1'b1;
        chk("pp_head12", rd4, 32'h12);
        step();
        chk("pp_count_same", {29'b0, cnt4}, 32'd2);
        chk("pp_head34",     rd4, 32'h34);
        rr4 = 1'b0; wd4 = 32'h56;
        step();
        wd4 = 32'h57;
        step();
        chk("pp_full_count", {29'b0, cnt4}, 32'd4);
        wd4 = 32'h58; rr4 = 1'b1;
        chk("pp_full_wr_ready", {31'b0, wr4}, 32'd0);
        step();
        chk("pp_full_count3", {29'b0, cnt4}, 32'd3);
        chk("pp_full_head55", rd4, 32'h55);
        chk("pp_refused_ready", {31'b0, wr4}, 32'd1);
        rr4 = 1'b0;
        step();
        chk("pp_refill_count", {29'b0, cnt4}, 32'd4);
        wv4 = 1'b0; rr4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain_data", rd4, 32'h55 + 32'(i));
            step();
        end
        chk("pp_drain_count", {29'b0, cnt4}, 32'd0);
        rr4 = 1'b0;

        // Clear at count=3 with both handshakes requested
        wv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wd4 = 32'h61 + 32'(i);
            step();
        end
        chk("clr_pre_count", {29'b0, cnt4}, 32'd3);
        clear = 1'b1; wd4 = 32'h99; rr4 = 1'b1;
        #1;
        chk("clr_wr_ready", {31'b0, wr4}, 32'd0);
        chk("clr_rd_valid", {31'b0, rv4}, 32'd0);
        step();
        clear = 1'b0; wv4 = 1'b0; rr4 = 1'b0;
        #1;
        chk("clr_count",     {29'b0, cnt4}, 32'd0);
        chk("clr_rd_valid2", {31'b0, rv4},  32'd0);
        wv4 = 1'b1; wd4 = 32'h77;
        step();
        wv4 = 1'b0;
        chk("clr_next_valid", {31'b0, rv4},  32'd1);
        chk("clr_next_data",  rd4,           32'h77);
        chk("clr_next_count", {29'b0, cnt4}, 32'd1);

        // DEPTH=3 stream with random consumer stalls
        for (int i = 0; i < 10; i++) words[i] = $urandom;
        sent = 0; rcvd = 0; mcnt = 0; cyc = 0;
        while (rcvd < 10 && cyc < 300) begin
            wv3 = (sent < 10);
            wd3 = (sent < 10) ? words[sent] : 32'h0;
            rr3 = 1'($urandom_range(0, 1));
            #1;
            mpush = wv3 && (mcnt != 3);
            mpop  = rr3 && (mcnt != 0);
            got   = rd3;
            if (mpop) begin
                chk("wrap_data", got, words[rcvd]);
                rcvd++;
            end
            if (mpush) sent++;
            mcnt = mcnt + (mpush ? 1 : 0) - (mpop ? 1 : 0);
            step();
            cyc++;
            chk("wrap_count", {30'b0, cnt3}, 32'(mcnt));
            chk("wrap_afull", {31'b0, af3},  (mcnt >= 2) ? 32'd1 : 32'd0);
        end
        wv3 = 1'b0; rr3 = 1'b0;
        chk("wrap_all_received", 32'(rcvd), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
